program_counter: RTL and testbench
==================================

# program_counter

Registered WIDTH-bit program counter for the gate-level datapath, built on the single-bit gate library (sNAND, sNOT, sAND, sOR, sXOR, sMUX). Each cycle it holds, increments, loads an external address, or clears, with fixed priority. It sits directly downstream of the gate library and upstream of instruction-address decode. It also emits a registered one-cycle wrap flag when an increment rolls over.

## Interface
- WIDTH, 16, counter width in bits (≥2)
- RESET_VALUE, 0, value of `out` after async reset and after `clr`

- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  asynchronous, active-low reset
- in  input  WIDTH  address to load
- load  input  1  load `in` at next edge
- inc  input  1  increment at next edge
- clr  input  1  synchronous clear to RESET_VALUE
- out  output  WIDTH  current count (registered)
- wrap  output  1  registered; high for one cycle after an increment from all-ones

## Operation
- One clock, `clk`. Reset is asynchronous and active-low on `rst_n`.
- Per-edge priority: clr > load > inc > hold.
  - clr: out ← RESET_VALUE, wrap ← 0.
  - load: out ← in, wrap ← 0. `inc` is ignored.
  - inc: out ← out + 1 mod 2^WIDTH. wrap ← 1 only if out was all-ones, else 0.
  - none: out holds, wrap ← 0.
- Increment path is a ripple half-adder chain: bit i sum = sXOR(out[i], c[i]); carry c[i+1] = sAND(out[i], c[i]); c[0] = 1'b1.
- The raw carry c[WIDTH] feeds the wrap register.
- Next-state select uses a three-level sMUX cascade per bit, where sel=1 selects the first data input:
  - level 1: inc chooses sum vs. out
  - level 2: load chooses in vs. level 1
  - level 3: clr chooses RESET_VALUE bit vs. level 2
- Storage is the only behavioural logic: one flop per bit plus one for wrap.
- No internal FSM beyond the counter state. Effectively a 2^WIDTH-state counter.

## Timing
- Async reset: while rst_n=0, out=RESET_VALUE and wrap=0 immediately, independent of clk.
- Reset deassertion is treated as synchronous to clk by the integrator. The first functional edge is the first rising edge with rst_n=1.
- Latency: one cycle. Controls and `in` sampled at rising edge N appear on out/wrap after edge N.
- No combinational path from any input to out or wrap.
- wrap is high for exactly one cycle per rollover. Back-to-back incs through all-ones produce a single pulse.
- Simultaneous events:
  - load+inc → load wins.
  - clr+anything → clr wins.
  - load of all-ones followed by inc → out=0 and wrap=1 on the following edge.
- Reset mid-operation: rst_n falling between edges forces RESET_VALUE at once. No pending load or inc survives.
- The combinational ripple depth is WIDTH XOR/AND stages plus 3 mux levels and must meet one clk period.

## Structure
- Shared package `gates_pkg` holds:
  - PC_WIDTH = 16
  - PC_RESET = 16'h0000
  - the control-priority constants, shared with the future decode stage
- One sub-module: `pc_bit_cell`, one bit comprising:
  - half-adder (sXOR + sAND)
  - three cascaded sMUX instances
  - the flop with async active-low reset to its RESET_VALUE bit
  - carry-in/carry-out ports for chaining
- `program_counter` generates WIDTH cells, chains the carries, and registers the final carry into wrap.

## Test plan
- rst_n=0 with in=16'hBEEF, load=1 → out=16'h0000, wrap=0 throughout, even with no clk edge.
- Release reset, inc=1 for 5 cycles → out steps 1,2,3,4,5; wrap stays 0.
- load=1, in=16'hFFFE, then inc=1 for 3 cycles → out=FFFE, FFFF, 0000, 0001; wrap=1 only in the cycle out=0000.
- load=1, inc=1, in=16'h1234 together → out=16'h1234, not 16'h1235. Then clr=1, load=1, in=16'h5555 → out=16'h0000.
- out=16'h00A0 with inc held, rst_n pulsed low mid-cycle → out=16'h0000 asynchronously. Counting resumes 1,2,… after release.
- All controls low for 4 cycles at out=16'h0042 → out stays 16'h0042, wrap=0.

Source files
------------

// File: rtl/gates_pkg.sv
// gates_pkg
// Shared constants for the gate-level datapath.
//   PC_WIDTH          default program-counter width
//   PC_RESET          default program-counter reset/clear value
//   PC_PRI_*          control priority ranks (higher rank wins); the decode
//                     stage uses the same ordering
//   pc_op_e           resolved per-edge operation
//   pc_resolve_op()   collapses the raw control bits into one operation
package gates_pkg;

    localparam int                  PC_WIDTH = 16;
    localparam logic [PC_WIDTH-1:0] PC_RESET = 16'h0000;

    localparam int PC_PRI_CLR  = 3;
    localparam int PC_PRI_LOAD = 2;
    localparam int PC_PRI_INC  = 1;
    localparam int PC_PRI_HOLD = 0;

    typedef enum logic [1:0] {
        PC_OP_HOLD = 2'd0,
        PC_OP_INC  = 2'd1,
        PC_OP_LOAD = 2'd2,
        PC_OP_CLR  = 2'd3
    } pc_op_e;

    function automatic pc_op_e pc_resolve_op(input logic clr, input logic load,
                                             input logic inc);
        pc_op_e op;
        op = PC_OP_HOLD;
        if (clr)       op = PC_OP_CLR;
        else if (load) op = PC_OP_LOAD;
        else if (inc)  op = PC_OP_INC;
        return op;
    endfunction

endpackage

// File: rtl/gates_lib.sv
// Single-bit gate library used by the gate-level datapath.
//   sNAND/sAND/sOR/sXOR : a, b -> y
//   sNOT                : a -> y
//   sMUX                : y = sel ? a : b  (sel=1 picks the first data input)
module sNAND (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a & b);
endmodule

module sNOT (
    input  logic a,
    output logic y
);
    assign y = ~a;
endmodule

module sAND (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

module sOR (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a | b;
endmodule

module sXOR (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

module sMUX (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);
    assign y = sel ? a : b;
endmodule

// File: rtl/program_counter_bit_cell.sv
// pc_bit_cell
// One bit of the program counter: half-adder, three-level select cascade and
// the storage flop.
//   clk, rst_n   clock and asynchronous active-low reset
//   i_in         load data bit
//   i_load       load select
//   i_inc        increment select
//   i_clr        synchronous clear select
//   i_carry      carry from the bit below (1 for bit 0)
//   o_carry      carry to the bit above
//   o_q          registered bit value
module pc_bit_cell #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_in,
    input  logic i_load,
    input  logic i_inc,
    input  logic i_clr,
    input  logic i_carry,
    output logic o_carry,
    output logic o_q
);

    logic r_q;
    logic w_sum;
    logic w_lvl1;
    logic w_lvl2;
    logic w_next;

    sXOR u_sum   (.a(r_q), .b(i_carry), .y(w_sum));
    sAND u_carry (.a(r_q), .b(i_carry), .y(o_carry));

    // Lowest-priority control sits nearest the adder so that clr, at the
    // last level, overrides everything below it.
    sMUX u_mux_inc  (.a(w_sum),     .b(r_q),    .sel(i_inc),  .y(w_lvl1));
    sMUX u_mux_load (.a(i_in),      .b(w_lvl1), .sel(i_load), .y(w_lvl2));
    sMUX u_mux_clr  (.a(RESET_BIT), .b(w_lvl2), .sel(i_clr),  .y(w_next));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_q <= RESET_BIT;
        else        r_q <= w_next;
    end

    assign o_q = r_q;

endmodule

// File: rtl/program_counter.sv
// program_counter
// Registered WIDTH-bit program counter with clr > load > inc > hold priority
// and a one-cycle wrap pulse after an increment from all-ones.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   in     address to load
//   load   load `in` at next edge
//   inc    increment at next edge
//   clr    synchronous clear to RESET_VALUE
//   out    current count (registered)
//   wrap   registered rollover flag
module program_counter
    import gates_pkg::*;
#(
    parameter int               WIDTH       = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] out,
    output logic             wrap
);

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_q;
    logic             w_wrap_lvl1;
    logic             w_wrap_lvl2;
    logic             w_wrap_next;
    logic             r_wrap;

    assign w_carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            pc_bit_cell #(
                .RESET_BIT (RESET_VALUE[gi])
            ) u_cell (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_in    (in[gi]),
                .i_load  (load),
                .i_inc   (inc),
                .i_clr   (clr),
                .i_carry (w_carry[gi]),
                .o_carry (w_carry[gi+1]),
                .o_q     (w_q[gi])
            );
        end
    endgenerate

    // The top carry is high whenever the count is all-ones, increment or not,
    // so it only reaches the wrap flop when the edge actually increments.
    sMUX u_wrap_inc  (.a(w_carry[WIDTH]), .b(1'b0),        .sel(inc),  .y(w_wrap_lvl1));
    sMUX u_wrap_load (.a(1'b0),           .b(w_wrap_lvl1), .sel(load), .y(w_wrap_lvl2));
    sMUX u_wrap_clr  (.a(1'b0),           .b(w_wrap_lvl2), .sel(clr),  .y(w_wrap_next));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_wrap <= 1'b0;
        else        r_wrap <= w_wrap_next;
    end

    assign out  = w_q;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_program_counter.sv
module tb_program_counter;

    localparam int          W     = 16;
    localparam logic [15:0] RST_V = 16'h0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  pc_in;
    logic          load;
    logic          inc;
    logic          clr;
    logic [W-1:0]  pc_out;
    logic          wrap;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] exp_out;
    logic         exp_wrap;

    always #5 clk = ~clk;

    program_counter #(
        .WIDTH       (W),
        .RESET_VALUE (RST_V)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (pc_in),
        .load  (load),
        .inc   (inc),
        .clr   (clr),
        .out   (pc_out),
        .wrap  (wrap)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag);
        $display("[TB] %s: in=%h clr=%b load=%b inc=%b -> out=%h wrap=%b (exp %h/%b)",
                 tag, pc_in, clr, load, inc, pc_out, wrap, exp_out, exp_wrap);
        tests++;
        assert (pc_out === exp_out) else begin
            fails++;
            $error("FAIL %s out: got %h want %h", tag, pc_out, exp_out);
        end
        tests++;
        assert (wrap === exp_wrap) else begin
            fails++;
            $error("FAIL %s wrap: got %b want %b", tag, wrap, exp_wrap);
        end
    endtask

    // Reference model: behaviour stated as arithmetic on the whole count.
    task automatic model_edge();
        if (!rst_n) begin
            exp_out  = RST_V;
            exp_wrap = 1'b0;
        end else if (clr) begin
            exp_out  = RST_V;
            exp_wrap = 1'b0;
        end else if (load) begin
            exp_out  = pc_in;
            exp_wrap = 1'b0;
        end else if (inc) begin
            exp_wrap = (exp_out == {W{1'b1}});
            exp_out  = W'((32'(exp_out) + 32'd1) % 32'h10000);
        end else begin
            exp_wrap = 1'b0;
        end
    endtask

    task automatic step(input logic c, input logic l, input logic i,
                        input logic [W-1:0] d, input string tag);
        clr   = c;
        load  = l;
        inc   = i;
        pc_in = d;
        @(posedge clk);
        model_edge();
        #1;
        check(tag);
    endtask

    initial begin
        // Async reset with a load pending, checked before any clock edge.
        rst_n = 1'b0;
        pc_in = 16'hBEEF;
        load  = 1'b1;
        inc   = 1'b0;
        clr   = 1'b0;
        exp_out  = RST_V;
        exp_wrap = 1'b0;
        #1;
        check("reset_no_edge");
        @(posedge clk);
        #1;
        check("reset_with_edge");

        // Release reset away from the edge.
        @(negedge clk);
        rst_n = 1'b1;
        load  = 1'b0;

        for (int k = 1; k <= 5; k++) step(1'b0, 1'b0, 1'b1, 16'h0000, "inc_from_reset");

        step(1'b0, 1'b1, 1'b0, 16'hFFFE, "load_fffe");
        step(1'b0, 1'b0, 1'b1, 16'h0000, "inc_to_ffff");
        step(1'b0, 1'b0, 1'b1, 16'h0000, "inc_wrap");
        step(1'b0, 1'b0, 1'b1, 16'h0000, "inc_after_wrap");

        step(1'b0, 1'b1, 1'b1, 16'h1234, "load_beats_inc");
        step(1'b1, 1'b1, 1'b0, 16'h5555, "clr_beats_load");

        // Load of all-ones then inc gives 0 with wrap.
        step(1'b0, 1'b1, 1'b0, 16'hFFFF, "load_ffff");
        step(1'b0, 1'b0, 1'b1, 16'h0000, "inc_ffff_wrap");
        // At all-ones without inc the top carry must not leak into wrap.
        step(1'b0, 1'b1, 1'b0, 16'hFFFF, "load_ffff_again");
        step(1'b0, 1'b0, 1'b0, 16'h0000, "hold_ffff_nowrap");
        step(1'b1, 1'b0, 1'b1, 16'h0000, "clr_beats_inc_at_ffff");

        // Mid-cycle asynchronous reset while counting from 00A0.
        step(1'b0, 1'b1, 1'b0, 16'h00A0, "load_00a0");
        step(1'b0, 1'b0, 1'b1, 16'h0000, "inc_00a1");
        @(negedge clk);
        #2;
        rst_n    = 1'b0;
        exp_out  = RST_V;
        exp_wrap = 1'b0;
        #1;
        check("async_reset_mid_cycle");
        @(posedge clk);
        #1;
        check("reset_held_inc");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) step(1'b0, 1'b0, 1'b1, 16'h0000, "resume_count");

        // Hold at 0042.
        step(1'b0, 1'b1, 1'b0, 16'h0042, "load_0042");
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 16'hABCD, "hold_0042");

        // Randomised traffic, biased toward loads near all-ones to exercise wrap.
        for (int k = 0; k < 400; k++) begin
            int unsigned r;
            logic [W-1:0] d;
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 1) == 0) d = 16'hFFF0 | W'($urandom_range(0, 15));
            else                           d = W'($urandom);
            step(r < 5, (r >= 5) && (r < 20), $urandom_range(0, 3) != 0, d, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
